// File: rtl/beta_dac_pkg.sv
// Shared constants, types and helpers for the 6-element unary Beta DAC path.
package beta_dac_pkg;

  localparam int unsigned NUM_ELEM     = 6;
  localparam int unsigned CODE_W       = 3;
  localparam logic [2:0]  CODE_MAX     = 3'd6;
  localparam logic [2:0]  CODE_ILLEGAL = 3'd7;

  typedef enum logic {
    MODE_STATIC = 1'b0,
    MODE_DWA    = 1'b1
  } mode_e;

  typedef struct packed {
    logic [5:0] elem;
    logic [2:0] ptr;
  } sel_t;

  // Thermometer code: the n LSBs set; anything above CODE_MAX yields zero.
  function automatic logic [5:0] therm6(input logic [2:0] code);
    logic [5:0] t;
    t = '0;
    case (code)
      3'd0:    t = 6'b000000;
      3'd1:    t = 6'b000001;
      3'd2:    t = 6'b000011;
      3'd3:    t = 6'b000111;
      3'd4:    t = 6'b001111;
      3'd5:    t = 6'b011111;
      3'd6:    t = 6'b111111;
      default: t = 6'b000000;
    endcase
    return t;
  endfunction

  // Rotate a 6-bit vector left by 0..5; out-of-range shifts pass through.
  function automatic logic [5:0] rotl6(input logic [5:0] vec, input logic [2:0] sh);
    logic [5:0] r;
    r = vec;
    case (sh)
      3'd1:    r = {vec[4:0], vec[5]};
      3'd2:    r = {vec[3:0], vec[5:4]};
      3'd3:    r = {vec[2:0], vec[5:3]};
      3'd4:    r = {vec[1:0], vec[5:2]};
      3'd5:    r = {vec[0],   vec[5:1]};
      default: r = vec;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dwa_rotator6_beta_if.sv
// Sample/output bundle between the Beta code source, the DWA selector and the elements.
interface dwa_rotator6_beta_if;
  import beta_dac_pkg::*;

  logic       en;
  logic [2:0] code_in;
  logic       mode;
  logic       err_clr;
  logic [5:0] elem_out;
  logic       out_valid;
  logic [2:0] ptr;
  logic       code_err;

  modport master (
    output en, code_in, mode, err_clr,
    input  elem_out, out_valid, ptr, code_err
  );

  modport slave (
    input  en, code_in, mode, err_clr,
    output elem_out, out_valid, ptr, code_err
  );
endinterface

// File: rtl/dwa_sel6_comb.sv
// Combinational element selection: next element enables and next pointer.
module dwa_sel6_comb
  import beta_dac_pkg::*;
(
  input  logic [2:0] code,
  input  logic [2:0] ptr,
  input  mode_e      mode,
  output sel_t       sel
);

  logic [3:0] sum;
  logic [2:0] ptr_wrap;

  // Pointer advance modulo 6 with a single compare/subtract on a 4-bit sum.
  always_comb begin
    sum      = {1'b0, ptr} + {1'b0, code};
    ptr_wrap = (sum >= 4'd6) ? 3'(sum - 4'd6) : sum[2:0];
  end

  // Select elements: illegal -> none, static -> thermometer, DWA -> rotated thermometer.
  always_comb begin
    sel.elem = '0;
    sel.ptr  = ptr;
    if (code == CODE_ILLEGAL) begin
      sel.elem = '0;
      sel.ptr  = ptr;
    end else if (mode == MODE_DWA) begin
      sel.elem = rotl6(therm6(code), ptr);
      sel.ptr  = ptr_wrap;
    end else begin
      sel.elem = therm6(code);
      sel.ptr  = ptr;
    end
  end

endmodule

// File: rtl/dwa_rotator6_beta.sv
// DWA element selector for the 6-element Beta DAC: sample register, selection, output registers.
module dwa_rotator6_beta
  import beta_dac_pkg::*;
#(
  parameter logic [2:0] PTR_INIT = 3'd0
) (
  input logic                 clk,
  input logic                 rst,
  dwa_rotator6_beta_if.slave  bus
);

  logic       s_vld;
  logic [2:0] s_code;
  mode_e      s_mode;
  logic       s_clr;

  logic [5:0] elem_q;
  logic       valid_q;
  logic [2:0] ptr_q;
  logic       err_q;

  sel_t       sel;

  // Sample stage; err_clr travels with the sample so clear/set ordering follows input order.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_vld  <= 1'b0;
      s_code <= '0;
      s_mode <= MODE_STATIC;
      s_clr  <= 1'b0;
    end else begin
      s_vld <= bus.en;
      s_clr <= bus.err_clr;
      if (bus.en) begin
        s_code <= bus.code_in;
        s_mode <= mode_e'(bus.mode);
      end
    end
  end

  dwa_sel6_comb u_sel (
    .code (s_code),
    .ptr  (ptr_q),
    .mode (s_mode),
    .sel  (sel)
  );

  // Output stage: element enables, pointer, valid strobe and sticky error (set beats clear).
  always_ff @(posedge clk) begin
    if (rst) begin
      elem_q  <= '0;
      valid_q <= 1'b0;
      ptr_q   <= PTR_INIT;
      err_q   <= 1'b0;
    end else begin
      valid_q <= s_vld;
      if (s_vld) begin
        elem_q <= sel.elem;
        ptr_q  <= sel.ptr;
      end
      if (s_vld && (s_code == CODE_ILLEGAL)) begin
        err_q <= 1'b1;
      end else if (s_clr) begin
        err_q <= 1'b0;
      end
    end
  end

  assign bus.elem_out  = elem_q;
  assign bus.out_valid = valid_q;
  assign bus.ptr       = ptr_q;
  assign bus.code_err  = err_q;

endmodule

// File: tb/tb_dwa_rotator6_beta.sv
// Scoreboard bench for dwa_rotator6_beta: directed vectors plus a long random DWA run.
module tb_dwa_rotator6_beta;
  import beta_dac_pkg::*;

  localparam logic [2:0] PTR_INIT = 3'd0;

  typedef struct {
    logic [5:0] elem;
    logic [2:0] ptr;
    logic       err;
    logic       track;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dwa_rotator6_beta_if bus ();

  dwa_rotator6_beta #(.PTR_INIT(PTR_INIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t        q[$];
  int unsigned errors = 0;
  int unsigned checks = 0;
  logic        err_m;
  int unsigned usage[6];

  // Direct comparison of a DUT output against a bench constant.
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs and push the expected response for accepted samples.
  task automatic drive(input logic e, input logic [2:0] c, input logic m, input logic clr,
                       input logic [5:0] xe, input logic [2:0] xp, input logic trk);
    exp_t x;
    @(negedge clk);
    bus.en      = e;
    bus.code_in = c;
    bus.mode    = m;
    bus.err_clr = clr;
    if (e && (c == 3'd7)) err_m = 1'b1;
    else if (clr)         err_m = 1'b0;
    if (e) begin
      x.elem  = xe;
      x.ptr   = xp;
      x.err   = err_m;
      x.track = trk;
      q.push_back(x);
    end
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, 1'b1, 1'b0, 6'b0, 3'd0, 1'b0);
  endtask

  // Independent DWA model: set element (p+i) mod 6 for each of the n units.
  function automatic logic [5:0] model_dwa(input int unsigned n, input int unsigned p);
    logic [5:0] v;
    v = '0;
    for (int unsigned i = 0; i < n; i++) v[(p + i) % 6] = 1'b1;
    return v;
  endfunction

  // Monitor: pop and compare whenever the DUT presents a valid output.
  always @(negedge clk) begin
    exp_t x;
    int unsigned mx, mn;
    if (bus.out_valid === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: elem=%b ptr=%0d with empty queue", bus.elem_out, bus.ptr);
      end else begin
        x = q.pop_front();
        if (bus.elem_out !== x.elem || bus.ptr !== x.ptr || bus.code_err !== x.err) begin
          errors++;
          $display("FAIL out: got elem=%b ptr=%0d err=%b expected elem=%b ptr=%0d err=%b",
                   bus.elem_out, bus.ptr, bus.code_err, x.elem, x.ptr, x.err);
        end
        if (x.track) begin
          for (int k = 0; k < 6; k++) usage[k] += 32'(bus.elem_out[k]);
          if (x.ptr == 3'd0) begin
            mx = usage[0];
            mn = usage[0];
            for (int k = 1; k < 6; k++) begin
              if (usage[k] > mx) mx = usage[k];
              if (usage[k] < mn) mn = usage[k];
            end
            checks++;
            if (mx - mn > 1) begin
              errors++;
              $display("FAIL usage_spread: got %0d expected <=1", mx - mn);
            end
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    int unsigned mp, c, np, waited;
    for (int k = 0; k < 6; k++) usage[k] = 0;
    err_m       = 1'b0;
    rst         = 1'b1;
    bus.en      = 1'b0;
    bus.code_in = 3'd0;
    bus.mode    = 1'b1;
    bus.err_clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // 1: reset state held through idle cycles
    repeat (3) idle();
    chk("rst_elem",  32'(bus.elem_out),  32'h0);
    chk("rst_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_ptr",   32'(bus.ptr),       32'(PTR_INIT));
    chk("rst_err",   32'(bus.code_err),  32'h0);

    // 2: back-to-back DWA codes
    drive(1'b1, 3'd2, 1'b1, 1'b0, 6'b000011, 3'd2, 1'b0);
    drive(1'b1, 3'd3, 1'b1, 1'b0, 6'b011100, 3'd5, 1'b0);
    drive(1'b1, 3'd4, 1'b1, 1'b0, 6'b100111, 3'd3, 1'b0);

    // 3: full and empty codes keep the pointer
    drive(1'b1, 3'd6, 1'b1, 1'b0, 6'b111111, 3'd3, 1'b0);
    drive(1'b1, 3'd0, 1'b1, 1'b0, 6'b000000, 3'd3, 1'b0);

    // 4: illegal code, set-wins, then clear
    drive(1'b1, 3'd7, 1'b1, 1'b0, 6'b000000, 3'd3, 1'b0);
    drive(1'b1, 3'd7, 1'b1, 1'b1, 6'b000000, 3'd3, 1'b0);
    drive(1'b0, 3'd0, 1'b1, 1'b1, 6'b000000, 3'd0, 1'b0);
    idle();
    idle();
    chk("err_cleared", 32'(bus.code_err), 32'h0);

    // 5: static mode holds pointer; DWA resumes from it
    drive(1'b1, 3'd5, 1'b0, 1'b0, 6'b011111, 3'd3, 1'b0);
    drive(1'b1, 3'd2, 1'b1, 1'b0, 6'b011000, 3'd5, 1'b0);
    idle();
    idle();
    idle();
    chk("hold_valid", 32'(bus.out_valid), 32'h0);
    chk("hold_elem",  32'(bus.elem_out),  32'b011000);

    // 6: reset one cycle after a sample discards it
    @(negedge clk);
    bus.en      = 1'b1;
    bus.code_in = 3'd1;
    bus.mode    = 1'b1;
    @(negedge clk);
    bus.en = 1'b0;
    rst    = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    err_m = 1'b0;
    chk("mid_rst_elem",  32'(bus.elem_out),  32'h0);
    chk("mid_rst_ptr",   32'(bus.ptr),       32'(PTR_INIT));
    chk("mid_rst_valid", 32'(bus.out_valid), 32'h0);
    idle();
    idle();
    chk("mid_rst_no_out", 32'(bus.out_valid), 32'h0);
    chk("mid_rst_ptr2",   32'(bus.ptr),       32'(PTR_INIT));

    // 7: random legal codes in DWA mode against the model
    mp = 32'(PTR_INIT);
    for (int unsigned i = 0; i < 10000; i++) begin
      c  = $urandom_range(6);
      np = (mp + c) % 6;
      drive(1'b1, 3'(c), 1'b1, 1'b0, model_dwa(c, mp), 3'(np), 1'b1);
      mp = np;
    end
    idle();

    waited = 0;
    while (q.size() != 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending outputs expected 0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
